// File: rtl/miner_core_pkg.sv
// miner_core_pkg: shared state type and default phase lengths for the miner core sequencer
package miner_core_pkg;
  typedef enum logic [2:0] {IDLE, MSA, COMP, ADD, CHECK} seq_state_t;
  localparam int MSA_CYCLES_DEF = 48;
  localparam int COMP_CYCLES_DEF = 64;
endpackage

// File: rtl/miner_core_phase_timer.sv
// miner_core_phase_timer: phase round counter wrapping at i_limit
//   i_clr  : synchronous clear (wins over everything but rst)
//   i_hold : freeze the count this cycle
//   i_en   : count while a phase is active
//   i_limit: terminal count (phase length - 1)
//   o_cnt  : current round index
//   o_last : o_cnt is at the terminal count (phase ends this cycle)
module miner_core_phase_timer
  import miner_core_pkg::*;
#(
  parameter int RND_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_hold,
  input  logic             i_en,
  input  logic [RND_W-1:0] i_limit,
  output logic [RND_W-1:0] o_cnt,
  output logic             o_last
);
  logic [RND_W-1:0] r_cnt;
  assign o_cnt  = r_cnt;
  assign o_last = r_cnt == i_limit;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en && !i_hold) r_cnt <= o_last ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/miner_core_sequencer.sv
// miner_core_sequencer: multi-pass hash sequencer sweeping a nonce range
//   in : start, abort, stall, nonce_base, nonce_cnt, hit
//   out: msa_en, comp_en, add_en (Moore enables), round_idx, pass_idx, nonce,
//        busy, done (1-cycle pulse), found (valid with done)
//   MINER_CORE_SEQ_CYCLE_CNT_EN adds a saturating 32-bit cycle_cnt output.
module miner_core_sequencer
  import miner_core_pkg::*;
#(
  parameter int NUM_PASSES  = 3,
  parameter int MSA_CYCLES  = MSA_CYCLES_DEF,
  parameter int COMP_CYCLES = COMP_CYCLES_DEF,
  parameter int NONCE_W     = 32,
  parameter int RND_W       = 7
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              abort,
  input  logic                              stall,
  input  logic [NONCE_W-1:0]                nonce_base,
  input  logic [NONCE_W-1:0]                nonce_cnt,
  input  logic                              hit,
  output logic                              msa_en,
  output logic                              comp_en,
  output logic                              add_en,
  output logic [RND_W-1:0]                  round_idx,
  output logic [$clog2(NUM_PASSES+1)-1:0]   pass_idx,
  output logic [NONCE_W-1:0]                nonce,
  output logic                              busy,
  output logic                              done,
  output logic                              found
`ifdef MINER_CORE_SEQ_CYCLE_CNT_EN
  ,
  output logic [31:0]                       cycle_cnt
`endif
);
  localparam int PW = $clog2(NUM_PASSES + 1);
  seq_state_t r_state, w_next;
  logic [PW-1:0] r_pass;
  logic [NONCE_W-1:0] r_nonce, r_rem;
  logic r_done, r_found;
  logic w_abort, w_last, w_done, w_found;
  logic [RND_W-1:0] w_round;
  assign w_abort = abort && r_state != IDLE;
  miner_core_phase_timer #(.RND_W(RND_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (r_state == IDLE || w_abort),
    .i_hold (stall),
    .i_en   (r_state == MSA || r_state == COMP),
    .i_limit(r_state == MSA ? RND_W'(MSA_CYCLES - 1) : RND_W'(COMP_CYCLES - 1)),
    .o_cnt  (w_round),
    .o_last (w_last)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next  = r_state;
    w_done  = 1'b0;
    w_found = 1'b0;
    msa_en  = r_state == MSA;
    comp_en = r_state == COMP;
    add_en  = r_state == ADD;
    busy    = r_state != IDLE;
    if (r_state == IDLE) w_next = start ? MSA : IDLE;
    else if (abort) begin
      w_next = IDLE;
      w_done = 1'b1;
    end else if (!stall)
      case (r_state)
        MSA:     w_next = w_last ? COMP : MSA;
        COMP:    w_next = !w_last ? COMP : r_pass == PW'(NUM_PASSES - 1) ? CHECK : ADD;
        ADD:     w_next = MSA;
        CHECK: begin
          w_done  = hit || r_rem == '0;
          w_found = hit;
          w_next  = w_done ? IDLE : MSA;
        end
        default: w_next = IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pass  <= '0;
      r_nonce <= '0;
      r_rem   <= '0;
      r_done  <= 1'b0;
      r_found <= 1'b0;
    end else begin
      r_done  <= w_done;
      r_found <= w_found;
      if (r_state == IDLE && start) begin
        r_nonce <= nonce_base;
        r_rem   <= nonce_cnt == '0 ? '0 : nonce_cnt - 1'b1;
        r_pass  <= '0;
      end else if (!stall && !w_abort) begin
        if (r_state == ADD) r_pass <= r_pass + 1'b1;
        if (r_state == CHECK && !w_done) begin
          r_nonce <= r_nonce + 1'b1;
          r_rem   <= r_rem - 1'b1;
          r_pass  <= '0;
        end
      end
    end
  assign round_idx = w_round;
  assign pass_idx  = r_pass;
  assign nonce     = r_nonce;
  assign done      = r_done;
  assign found     = r_found;
`ifdef MINER_CORE_SEQ_CYCLE_CNT_EN
  logic [31:0] r_cyc;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cyc <= '0;
    else if (r_state == IDLE && start) r_cyc <= '0;
    else if (busy && !stall && r_cyc != '1) r_cyc <= r_cyc + 1'b1;
  assign cycle_cnt = r_cyc;
`endif
endmodule

// File: tb/tb_miner_core_sequencer.sv
// tb_miner_core_sequencer: directed checks of the miner core sequencer at default parameters
module tb_miner_core_sequencer;
  logic clk = 1'b0;
  logic rst, start, abort, stall, hit;
  logic [31:0] nonce_base, nonce_cnt;
  logic msa_en, comp_en, add_en, busy, done, found;
  logic [6:0] round_idx;
  logic [1:0] pass_idx;
  logic [31:0] nonce;
  logic [46:0] w_all;
  int n_vec = 0;
  int n_err = 0;

  miner_core_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .stall(stall),
    .nonce_base(nonce_base), .nonce_cnt(nonce_cnt), .hit(hit),
    .msa_en(msa_en), .comp_en(comp_en), .add_en(add_en), .round_idx(round_idx),
    .pass_idx(pass_idx), .nonce(nonce), .busy(busy), .done(done), .found(found)
  );

  assign w_all = {msa_en, comp_en, add_en, round_idx, pass_idx, nonce, busy, done, found};
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; afterwards we sit 1 time unit after edge 0.
  task automatic go(input logic [31:0] b, input logic [31:0] c);
    nonce_base = b;
    nonce_cnt  = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts cycles from now until done; hit pulses at hit_at plus a burst outside CHECK.
  task automatic run_to_done(input int hit_at, output int cyc);
    int n = 0;
    cyc = -1;
    while (n < 1500 && cyc < 0) begin
      hit = (n == hit_at) || (n >= 100 && n < 104);
      if (done) cyc = n;
      else begin
        tick();
        n++;
      end
    end
    hit = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_vec++;
    if (w_all !== 47'd0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", w_all); end
    rst = 1'b0;
    tick();
    n_vec++;
    if (w_all !== 47'd0) begin n_err++; $display("FAIL idle_outputs: got %h want 0", w_all); end
  endtask

  task automatic test_single();
    int n_msa = 0, n_comp = 0, n_add = 0, n_busy = 0, bad_hot = 0, d = -1;
    logic [10:0] s47 = '0, s48 = '0, s112 = '0, s113 = '0;
    go(32'h10, 32'd1);
    for (int n = 0; n < 400 && d < 0; n++) begin
      if (done) d = n;
      else begin
        n_msa  += int'(msa_en);
        n_comp += int'(comp_en);
        n_add  += int'(add_en);
        n_busy += int'(busy);
        if (int'(msa_en) + int'(comp_en) + int'(add_en) > 1) bad_hot++;
        if (n == 47)  s47  = {msa_en, comp_en, add_en, round_idx, pass_idx[0]};
        if (n == 48)  s48  = {msa_en, comp_en, add_en, round_idx, pass_idx[0]};
        if (n == 112) s112 = {msa_en, comp_en, add_en, round_idx, pass_idx[0]};
        if (n == 113) s113 = {msa_en, comp_en, add_en, round_idx, pass_idx[0]};
        start = (n == 50);
        nonce_base = (n == 50) ? 32'h99 : 32'h10;
        tick();
      end
    end
    start = 1'b0;
    n_vec++; if (n_msa !== 144) begin n_err++; $display("FAIL msa_cycles: got %0d want 144", n_msa); end
    n_vec++; if (n_comp !== 192) begin n_err++; $display("FAIL comp_cycles: got %0d want 192", n_comp); end
    n_vec++; if (n_add !== 2) begin n_err++; $display("FAIL add_pulses: got %0d want 2", n_add); end
    n_vec++; if (n_busy !== 339) begin n_err++; $display("FAIL busy_cycles: got %0d want 339", n_busy); end
    n_vec++; if (bad_hot !== 0) begin n_err++; $display("FAIL one_hot: got %0d bad cycles want 0", bad_hot); end
    n_vec++; if (s47 !== {3'b100, 7'd47, 1'b0}) begin n_err++; $display("FAIL msa_last: got %h want %h", s47, {3'b100, 7'd47, 1'b0}); end
    n_vec++; if (s48 !== {3'b010, 7'd0, 1'b0}) begin n_err++; $display("FAIL comp_first: got %h want %h", s48, {3'b010, 7'd0, 1'b0}); end
    n_vec++; if (s112 !== {3'b001, 7'd0, 1'b0}) begin n_err++; $display("FAIL add_first: got %h want %h", s112, {3'b001, 7'd0, 1'b0}); end
    n_vec++; if (s113 !== {3'b100, 7'd0, 1'b1}) begin n_err++; $display("FAIL pass1_msa: got %h want %h", s113, {3'b100, 7'd0, 1'b1}); end
    n_vec++; if (d !== 339) begin n_err++; $display("FAIL single_latency: got %0d want 339", d); end
    n_vec++; if ({found, nonce} !== {1'b0, 32'h10}) begin n_err++; $display("FAIL single_result: got found=%b nonce=%h want 0/00000010", found, nonce); end
  endtask

  task automatic test_hit();
    int d;
    go(32'h10, 32'd3);
    run_to_done(677, d);
    n_vec++; if (d !== 678) begin n_err++; $display("FAIL hit_latency: got %0d want 678", d); end
    n_vec++; if ({found, nonce} !== {1'b1, 32'h11}) begin n_err++; $display("FAIL hit_result: got found=%b nonce=%h want 1/00000011", found, nonce); end
  endtask

  task automatic test_wrap();
    int d;
    go(32'hFFFF_FFFF, 32'd2);
    run_to_done(-1, d);
    n_vec++; if (d !== 678) begin n_err++; $display("FAIL wrap_latency: got %0d want 678", d); end
    n_vec++; if ({found, nonce} !== {1'b0, 32'h0}) begin n_err++; $display("FAIL wrap_result: got found=%b nonce=%h want 0/00000000", found, nonce); end
  endtask

  task automatic test_cnt_zero();
    int d;
    go(32'h5, 32'd0);
    run_to_done(-1, d);
    n_vec++; if (d !== 339) begin n_err++; $display("FAIL cnt0_latency: got %0d want 339", d); end
    n_vec++; if (nonce !== 32'h5) begin n_err++; $display("FAIL cnt0_nonce: got %h want 00000005", nonce); end
  endtask

  task automatic test_stall();
    int d, bad = 0;
    go(32'h10, 32'd1);
    repeat (133) tick();
    n_vec++; if ({msa_en, round_idx, pass_idx} !== {1'b1, 7'd20, 2'd1}) begin n_err++; $display("FAIL stall_pos: got %h want %h", {msa_en, round_idx, pass_idx}, {1'b1, 7'd20, 2'd1}); end
    stall = 1'b1;
    repeat (5) begin
      tick();
      if ({msa_en, round_idx, pass_idx} !== {1'b1, 7'd20, 2'd1}) bad++;
    end
    stall = 1'b0;
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL stall_freeze: got %0d moved cycles want 0", bad); end
    run_to_done(-1, d);
    n_vec++; if (d + 138 !== 344) begin n_err++; $display("FAIL stall_latency: got %0d want 344", d + 138); end
  endtask

  task automatic test_stall_check();
    int bad = 0;
    go(32'h10, 32'd1);
    repeat (338) tick();
    n_vec++; if ({busy, msa_en, comp_en, add_en} !== 4'b1000) begin n_err++; $display("FAIL check_state: got %b want 1000", {busy, msa_en, comp_en, add_en}); end
    stall = 1'b1;
    repeat (2) begin
      tick();
      if ({busy, done} !== 2'b10) bad++;
    end
    stall = 1'b0;
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL check_stall: got %0d bad cycles want 0", bad); end
    tick();
    n_vec++; if ({busy, done, found} !== 3'b010) begin n_err++; $display("FAIL check_release: got %b want 010", {busy, done, found}); end
  endtask

  task automatic test_abort();
    int d;
    go(32'h10, 32'd2);
    repeat (284) tick();
    n_vec++; if ({comp_en, round_idx, pass_idx} !== {1'b1, 7'd10, 2'd2}) begin n_err++; $display("FAIL abort_pos: got %h want %h", {comp_en, round_idx, pass_idx}, {1'b1, 7'd10, 2'd2}); end
    abort = 1'b1;
    stall = 1'b1;
    tick();
    abort = 1'b0;
    stall = 1'b0;
    n_vec++; if ({msa_en, comp_en, add_en, busy, done, found, nonce} !== {6'b000010, 32'h10}) begin n_err++; $display("FAIL abort_next: got %h want %h", {msa_en, comp_en, add_en, busy, done, found, nonce}, {6'b000010, 32'h10}); end
    tick();
    n_vec++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL abort_pulse: got %b want 00", {busy, done}); end
    abort = 1'b1;
    tick();
    n_vec++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL abort_idle: got %b want 00", {busy, done}); end
    nonce_base = 32'h20;
    nonce_cnt  = 32'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    n_vec++; if ({busy, msa_en} !== 2'b11) begin n_err++; $display("FAIL start_abort: got %b want 11", {busy, msa_en}); end
    run_to_done(-1, d);
    n_vec++; if ({d, nonce} !== {32'd339, 32'h20}) begin n_err++; $display("FAIL start_abort_run: got %0d/%h want 339/00000020", d, nonce); end
  endtask

  task automatic test_async_reset();
    int d;
    go(32'h10, 32'd1);
    repeat (60) tick();
    rst = 1'b1;
    #1;
    n_vec++; if (w_all !== 47'd0) begin n_err++; $display("FAIL async_reset: got %h want 0", w_all); end
    rst = 1'b0;
    tick();
    go(32'h10, 32'd1);
    run_to_done(-1, d);
    n_vec++; if ({d, found, nonce} !== {32'd339, 1'b0, 32'h10}) begin n_err++; $display("FAIL after_reset: got %0d/%b/%h want 339/0/00000010", d, found, nonce); end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    stall = 1'b0;
    hit = 1'b0;
    nonce_base = '0;
    nonce_cnt = '0;
    test_reset();
    test_single();
    test_hit();
    test_wrap();
    test_cnt_zero();
    test_stall();
    test_stall_check();
    test_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
